// File: rtl/osd_pkg.sv
// Shared widths and types for the OSD pump to SRAM writer path.
package osd_pkg;
    localparam int SRAM_AW = 19;
    localparam int SRAM_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } wr_state_t;

    typedef struct packed {
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] data;
    } pump_entry_t;

    localparam int ENTRY_W = $bits(pump_entry_t);
endpackage

// File: rtl/pump_fifo.sv
// Small synchronous FIFO; extra pointer MSB separates full from empty.
module pump_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/osd_pump_sram_writer.sv
// Pclk-side consumer of the OSD pump: buffers pump bytes and writes them to
// SRAM, owning the bus while a pump is active; otherwise the core passes through.
//
// state  | meaning
// IDLE   | no write in flight; pops head when FIFO non-empty and bus is held
// SETUP  | address/data driven, WE# still high
// STROBE | WE# low for WE_CYCLES cycles (down-counter to terminal count)
// HOLD   | WE# high, address/data held; chain to next byte or return to IDLE
module osd_pump_sram_writer
    import osd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WE_CYCLES  = 2
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               pump_active_i,
    input  logic [SRAM_AW-1:0] pump_a_i,
    input  logic [SRAM_DW-1:0] pump_d_i,
    input  logic               pump_we_n_i,
    input  logic [SRAM_AW-1:0] core_a_i,
    input  logic [SRAM_DW-1:0] core_d_i,
    input  logic               core_we_n_i,
    input  logic               core_oe_n_i,
    output logic [SRAM_AW-1:0] sram_a_o,
    output logic [SRAM_DW-1:0] sram_d_o,
    output logic               sram_d_oe_o,
    output logic               sram_we_n_o,
    output logic               sram_oe_n_o,
    output logic               core_hold_o,
    output logic [SRAM_AW-1:0] bytes_o,
    output logic               overflow_o,
    output logic               done_o
);
    localparam logic [2:0] WE_LOAD = 3'(WE_CYCLES - 1);

    logic               act_s1, act_s2, act_s3;
    logic               we_s1, we_s2, we_s3;
    logic               we_fall, act_rise;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    pump_entry_t        push_entry, head;
    wr_state_t          state;
    logic [2:0]         we_cnt;
    logic               restart_pend;
    logic [SRAM_AW-1:0] wr_a;
    logic [SRAM_DW-1:0] wr_d;
    logic               wr_doe, wr_we_n;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            act_s1 <= 1'b0;
            act_s2 <= 1'b0;
            act_s3 <= 1'b0;
            we_s1  <= 1'b1;
            we_s2  <= 1'b1;
            we_s3  <= 1'b1;
        end else begin
            act_s1 <= pump_active_i;
            act_s2 <= act_s1;
            act_s3 <= act_s2;
            we_s1  <= pump_we_n_i;
            we_s2  <= we_s1;
            we_s3  <= we_s2;
        end
    end

    // Pump buses are stable for the whole strobe, so they are sampled directly.
    assign we_fall    = we_s3 & ~we_s2;
    assign act_rise   = act_s2 & ~act_s3;
    assign fifo_pop   = core_hold_o && !fifo_empty && (state == ST_IDLE || state == ST_HOLD);
    assign fifo_push  = we_fall && (!fifo_full || fifo_pop);
    assign push_entry = {pump_a_i, pump_d_i};

    pump_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .pclk  (pclk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            we_cnt       <= '0;
            wr_a         <= '0;
            wr_d         <= '0;
            wr_doe       <= 1'b0;
            wr_we_n      <= 1'b1;
            core_hold_o  <= 1'b0;
            restart_pend <= 1'b0;
            bytes_o      <= '0;
            overflow_o   <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        state  <= ST_SETUP;
                        wr_a   <= head.addr;
                        wr_d   <= head.data;
                        wr_doe <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state   <= ST_STROBE;
                    wr_we_n <= 1'b0;
                    we_cnt  <= WE_LOAD;
                end
                ST_STROBE: begin
                    if (we_cnt == 3'd0) begin
                        state   <= ST_HOLD;
                        wr_we_n <= 1'b1;
                        bytes_o <= bytes_o + 1'b1;
                    end else begin
                        we_cnt <= we_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (fifo_pop) begin
                        state <= ST_SETUP;
                        wr_a  <= head.addr;
                        wr_d  <= head.data;
                    end else begin
                        state  <= ST_IDLE;
                        wr_doe <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A restart seen while still draining is deferred until the FIFO empties.
            if (!core_hold_o) begin
                if (act_s2) begin
                    core_hold_o <= 1'b1;
                    bytes_o     <= '0;
                    overflow_o  <= 1'b0;
                end
            end else if (fifo_empty && state == ST_IDLE) begin
                if (restart_pend) begin
                    restart_pend <= 1'b0;
                    bytes_o      <= '0;
                    overflow_o   <= 1'b0;
                    done_o       <= 1'b1;
                end else if (!act_s2) begin
                    core_hold_o <= 1'b0;
                    done_o      <= 1'b1;
                end
            end
            if (core_hold_o && act_rise) restart_pend <= 1'b1;

            if (we_fall && fifo_full && !fifo_pop) overflow_o <= 1'b1;
        end
    end

    assign sram_a_o    = core_hold_o ? wr_a    : core_a_i;
    assign sram_d_o    = core_hold_o ? wr_d    : core_d_i;
    assign sram_d_oe_o = core_hold_o ? wr_doe  : ~core_we_n_i;
    assign sram_we_n_o = core_hold_o ? wr_we_n : core_we_n_i;
    assign sram_oe_n_o = core_hold_o ? 1'b1    : core_oe_n_i;
endmodule

// File: tb/tb_osd_pump_sram_writer.sv
// Directed bench for osd_pump_sram_writer: a WE_CYCLES=2 instance checked
// against an expected-write queue, and a WE_CYCLES=7 instance for overflow/drain.
module tb_osd_pump_sram_writer;
    import osd_pkg::*;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        pump_active = 1'b0;
    logic [18:0] pump_a = '0;
    logic [7:0]  pump_d = '0;
    logic        pump_we_n = 1'b1;
    logic [18:0] core_a = '0;
    logic [7:0]  core_d = '0;
    logic        core_we_n = 1'b1;
    logic        core_oe_n = 1'b1;

    logic [18:0] s_a, s_a7, bytes, bytes7;
    logic [7:0]  s_d, s_d7;
    logic        s_doe, s_doe7, s_we_n, s_we_n7, s_oe_n, s_oe_n7;
    logic        hold, hold7, ovf, ovf7, done, done7;

    int tests_run = 0;
    int tests_failed = 0;
    pump_entry_t exp_q[$];
    int writes = 0, writes7 = 0, done_cnt = 0, done_cnt7 = 0, lo_cnt = 0, lo_cnt7 = 0;
    logic prev_we = 1'b1, prev_we7 = 1'b1, have_last7 = 1'b0;
    logic [18:0] last_a7 = '0;

    always #5 pclk = ~pclk;

    osd_pump_sram_writer #(.FIFO_DEPTH(4), .WE_CYCLES(2)) dut (
        .pclk(pclk), .reset(reset), .pump_active_i(pump_active), .pump_a_i(pump_a),
        .pump_d_i(pump_d), .pump_we_n_i(pump_we_n), .core_a_i(core_a), .core_d_i(core_d),
        .core_we_n_i(core_we_n), .core_oe_n_i(core_oe_n), .sram_a_o(s_a), .sram_d_o(s_d),
        .sram_d_oe_o(s_doe), .sram_we_n_o(s_we_n), .sram_oe_n_o(s_oe_n), .core_hold_o(hold),
        .bytes_o(bytes), .overflow_o(ovf), .done_o(done)
    );

    osd_pump_sram_writer #(.FIFO_DEPTH(4), .WE_CYCLES(7)) dut7 (
        .pclk(pclk), .reset(reset), .pump_active_i(pump_active), .pump_a_i(pump_a),
        .pump_d_i(pump_d), .pump_we_n_i(pump_we_n), .core_a_i(core_a), .core_d_i(core_d),
        .core_we_n_i(core_we_n), .core_oe_n_i(core_oe_n), .sram_a_o(s_a7), .sram_d_o(s_d7),
        .sram_d_oe_o(s_doe7), .sram_we_n_o(s_we_n7), .sram_oe_n_o(s_oe_n7), .core_hold_o(hold7),
        .bytes_o(bytes7), .overflow_o(ovf7), .done_o(done7)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every WE# falling edge while the pump owns the bus is one SRAM write.
    always @(negedge pclk) begin
        pump_entry_t e;
        if (reset) begin
            prev_we = 1'b1; prev_we7 = 1'b1; lo_cnt = 0; lo_cnt7 = 0; have_last7 = 1'b0;
        end else begin
            if (done)  done_cnt++;
            if (done7) done_cnt7++;
            if (hold && prev_we && !s_we_n) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = 'x;
                check("wr_addr", 32'(s_a), 32'(e.addr));
                check("wr_data", 32'(s_d), 32'(e.data));
                check("wr_d_oe", 32'(s_doe), 32'd1);
                writes++;
            end
            if (hold && !s_we_n) lo_cnt++;
            if (hold && !prev_we && s_we_n) begin
                check("we_low_cycles", 32'(lo_cnt), 32'd2);
                lo_cnt = 0;
            end
            prev_we = hold ? s_we_n : 1'b1;

            if (hold7 && prev_we7 && !s_we_n7) begin
                if (have_last7) check("wr7_ascending", 32'(s_a7 > last_a7), 32'd1);
                last_a7 = s_a7;
                have_last7 = 1'b1;
                writes7++;
            end
            if (hold7 && !s_we_n7) lo_cnt7++;
            if (hold7 && !prev_we7 && s_we_n7) begin
                check("we7_low_cycles", 32'(lo_cnt7), 32'd7);
                lo_cnt7 = 0;
            end
            prev_we7 = hold7 ? s_we_n7 : 1'b1;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic send(input logic [18:0] a, input logic [7:0] d, input int lo, input int hi);
        pump_entry_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        pump_a = a;
        pump_d = d;
        pump_we_n = 1'b0;
        cycles(lo);
        pump_we_n = 1'b1;
        cycles(hi);
    endtask

    task automatic start_pump();
        have_last7 = 1'b0;
        pump_active = 1'b1;
        cycles(4);
    endtask

    task automatic wait_release(input string tag);
        int n = 0;
        while ((hold || hold7) && n < 600) begin
            cycles(1);
            n++;
        end
        check(tag, 32'({hold, hold7}), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, w7, d0, d7;
        cycles(3);
        reset = 1'b0;
        cycles(2);
        check("rst_we_n", 32'(s_we_n), 32'd1);
        check("rst_oe_n", 32'(s_oe_n), 32'd1);
        check("rst_d_oe", 32'(s_doe), 32'd0);
        check("rst_hold", 32'(hold), 32'd0);
        check("rst_bytes", 32'(bytes), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Single byte; core OE# asserted to show the pump blocks it.
        core_oe_n = 1'b0;
        w0 = writes; d0 = done_cnt;
        start_pump();
        check("single_hold", 32'(hold), 32'd1);
        check("single_oe_blocked", 32'(s_oe_n), 32'd1);
        send(19'h00000, 8'hA5, 8, 8);
        cycles(4);
        check("single_bytes", 32'(bytes), 32'd1);
        check("single_writes", 32'(writes - w0), 32'd1);
        pump_active = 1'b0;
        wait_release("single_release");
        cycles(2);
        check("single_done", 32'(done_cnt - d0), 32'd1);
        core_oe_n = 1'b1;

        // 256-byte stream at sck = pclk/4, 8 sck per byte.
        w0 = writes; d0 = done_cnt;
        start_pump();
        for (int i = 0; i < 256; i++) send(19'(i), 8'(i) ^ 8'hC3, 8, 24);
        pump_active = 1'b0;
        wait_release("stream_release");
        cycles(2);
        check("stream_writes", 32'(writes - w0), 32'd256);
        check("stream_bytes", 32'(bytes), 32'd256);
        check("stream_bytes7", 32'(bytes7), 32'd256);
        check("stream_ovf", 32'(ovf), 32'd0);
        check("stream_ovf7", 32'(ovf7), 32'd0);
        check("stream_queue_empty", 32'(exp_q.size()), 32'd0);
        check("stream_done", 32'(done_cnt - d0), 32'd1);

        // Fast burst: the 7-cycle writer falls behind and must drop bytes.
        w7 = writes7;
        start_pump();
        for (int i = 0; i < 16; i++) send(19'h00100 + 19'(i), 8'(i), 4, 2);
        pump_active = 1'b0;
        wait_release("ovf_release");
        cycles(2);
        check("ovf7_set", 32'(ovf7), 32'd1);
        check("ovf7_bytes_lt16", 32'(bytes7 < 19'd16), 32'd1);
        check("ovf7_bytes_vs_writes", 32'(bytes7), 32'(writes7 - w7));
        check("ovf_fast_clear", 32'(ovf), 32'd0);
        check("ovf_fast_bytes", 32'(bytes), 32'd16);
        check("ovf_queue_empty", 32'(exp_q.size()), 32'd0);

        // Pump ends with entries still queued in the slow writer.
        w7 = writes7; d7 = done_cnt7;
        start_pump();
        check("restart_ovf7_cleared", 32'(ovf7), 32'd0);
        for (int i = 0; i < 6; i++) send(19'h00200 + 19'(i), 8'h80 + 8'(i), 4, 2);
        pump_active = 1'b0;
        cycles(8);
        check("drain_hold7", 32'(hold7), 32'd1);
        wait_release("drain_release");
        check("drain_writes7", 32'(writes7 - w7), 32'd6);
        cycles(2);
        check("drain_bytes7", 32'(bytes7), 32'd6);
        check("drain_bytes", 32'(bytes), 32'd6);
        check("drain_done7", 32'(done_cnt7 - d7), 32'd1);

        // Core pass-through.
        core_a = 19'h12345; core_d = 8'h3C; core_we_n = 1'b0;
        #1;
        check("pt_addr", 32'(s_a), 32'h12345);
        check("pt_data", 32'(s_d), 32'h3C);
        check("pt_d_oe", 32'(s_doe), 32'd1);
        check("pt_we_n", 32'(s_we_n), 32'd0);
        check("pt_oe_n", 32'(s_oe_n), 32'd1);
        check("pt_hold", 32'(hold), 32'd0);
        core_we_n = 1'b1; core_oe_n = 1'b0;
        #1;
        check("pt_read_oe_n", 32'(s_oe_n), 32'd0);
        check("pt_read_d_oe", 32'(s_doe), 32'd0);
        check("pt_read_we_n", 32'(s_we_n), 32'd1);
        cycles(1);
        core_oe_n = 1'b1;
        cycles(2);

        // Reset in the middle of a strobe, then a clean pump afterwards.
        start_pump();
        begin
            pump_entry_t e;
            int n;
            e.addr = 19'h00777; e.data = 8'h11;
            exp_q.push_back(e);
            pump_a = e.addr; pump_d = e.data; pump_we_n = 1'b0;
            n = 0;
            while (s_we_n && n < 20) begin
                cycles(1);
                n++;
            end
            check("rst_strobe_seen", 32'(s_we_n), 32'd0);
        end
        #2;
        reset = 1'b1;
        #1;
        check("midrst_we_n", 32'(s_we_n), 32'd1);
        check("midrst_hold", 32'(hold), 32'd0);
        check("midrst_bytes", 32'(bytes), 32'd0);
        check("midrst_d_oe", 32'(s_doe), 32'd0);
        check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        pump_we_n = 1'b1;
        pump_active = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(3);
        w0 = writes; d0 = done_cnt;
        start_pump();
        send(19'h00042, 8'h5A, 8, 8);
        cycles(4);
        check("post_rst_bytes", 32'(bytes), 32'd1);
        check("post_rst_writes", 32'(writes - w0), 32'd1);
        pump_active = 1'b0;
        wait_release("post_rst_release");
        cycles(2);
        check("post_rst_done", 32'(done_cnt - d0), 32'd1);
        check("post_rst_bytes7", 32'(bytes7), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
